crc32_frame_checker: RTL and testbench
======================================

// Module: crc32_frame_checker
// PURPOSE
// - Receive-side companion of the combinational CRC32 byte generator (reflected, poly 0xEDB88320, init/xorout 0xFFFFFFFF).
// - Consumes a byte stream framed by in_last; each frame carries a 4-byte FCS appended LSB-first.
// - Runs CRC over all bytes including FCS, checks the residue, and reports per-frame ok/err/length.
// - Sits between the byte deserialiser and the packet consumer.
// PARAMETERS
// - POLY     32'hEDB88320  reflected CRC32 polynomial
// - RESIDUE  32'hDEBB20E3  good-frame register value (before final inversion) after data+FCS
// - CNT_W    16            frame byte-count width
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      input byte valid
// - in_ready   out  1      input byte accepted when in_valid & in_ready
// - in_data    in   8      frame byte
// - in_last    in   1      marks last byte (final FCS byte) of frame
// - res_valid  out  1      frame result valid; held until res_ready
// - res_ready  in   1      result consumed when res_valid & res_ready
// - res_ok     out  1      1 = residue matched and length >= 4
// - res_runt   out  1      1 = frame shorter than 4 bytes
// - res_len    out  CNT_W  bytes in frame incl. FCS, saturating at all-ones
// - out_valid/out_ready/out_data[7:0]/out_last: payload stream, present only with CRC32_CHECK_STRIP_EN
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, crc=32'hFFFFFFFF, len=0; res_valid=0, res_ok=0, res_runt=0, res_len=0, out_valid=0.
// - Byte step: 8 LSB-first iterations: crc = (crc>>1) ^ (crc[0] ? POLY : 0), after crc ^= {24'h0,byte}.
//   Combinational per-byte update; one byte per clock max.
// - FSM IDLE: in_ready=1; first accepted byte -> crc=step(FFFFFFFF,b), len=1, go RUN.
//   If that byte has in_last, go REPORT instead.
// - FSM RUN: in_ready=1; each accepted byte -> crc=step(crc,b), len=len+1 (saturating).
//   An accepted byte with in_last -> REPORT.
// - On the in_last acceptance, register results using post-step crc and len:
//   res_ok=(crc==RESIDUE)&&(len>=4); res_runt=(len<4).
// - FSM REPORT: res_valid=1 (first asserted cycle after last byte accepted), in_ready=0.
//   Results stable while res_valid & !res_ready.
//   On res_ready: crc=FFFFFFFF, len=0, go IDLE. One-cycle bubble between frames is required.
// - Runt frame (len<4): res_ok=0, res_runt=1, always.
// - Count saturation: len stops at 2^CNT_W-1; ok/runt unaffected.
// - Reset mid-frame: partial frame discarded, no result produced.
// - No timeout: an unterminated frame stays in RUN indefinitely.
// CONFIGURATION
// - CRC32_CHECK_STRIP_EN defined:
//   - 4-entry byte delay line forwards payload downstream with FCS removed.
//   - in_ready = (state!=REPORT) && (fill<4 || out_ready).
//   - out_valid = in_valid && fill==4 && state!=REPORT; out_data = oldest entry; out_last = in_last.
//   - fill clears on frame end/reset. Frames with len<=4 emit no payload bytes.
//   - The payload last byte and the FCS last byte transfer in the same cycle.
// - CRC32_CHECK_STRIP_EN undefined: out_* ports and delay line absent; in_ready = (state!=REPORT); check-only.
// TESTING
// - "123456789" (31..39) + FCS 26 39 F4 CB, last on CB -> res_ok=1, res_runt=0, res_len=13.
// - Single 00 + FCS 8D EF 02 D2 -> res_ok=1, res_len=5; flip bit0 of 00 -> res_ok=0.
// - Two-byte frame AA BB(last) -> res_ok=0, res_runt=1, res_len=2.
// - Hold res_ready=0 for 10 cycles after frame -> res_* stable, in_ready=0; release -> IDLE next cycle.
// - Assert rst mid-frame after 3 bytes, then send good 13-byte frame -> exactly one result, res_ok=1.
// - STRIP_EN, 123456789 frame, random out_ready stalls -> out bytes 31..39, out_last on 39, no FCS emitted.

Source files
------------

// File: rtl/crc32_frame_checker.sv
// crc32_frame_checker
// Receive-side CRC32 checker (reflected, poly 0xEDB88320, init/xorout 0xFFFFFFFF).
// Runs the CRC over every byte of a frame including its 4-byte LSB-first FCS,
// compares the register against the good-frame residue and reports ok/runt/length
// once per frame through a valid/ready result port.
// Optional feature macro: CRC32_CHECK_STRIP_EN adds a 4-byte delay line that
// forwards the payload downstream with the FCS removed.
module crc32_frame_checker #(
    parameter logic [31:0] POLY    = 32'hEDB88320,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
`ifdef CRC32_CHECK_STRIP_EN
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_runt,
    output logic [CNT_W-1:0] res_len
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT
    } state_t;

    state_t           state_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic             accept;

    // One byte through the reflected CRC: xor the byte into the low bits, then
    // eight LSB-first shift/conditional-xor iterations.
    function automatic logic [31:0] crcByte(input logic [31:0] crcIn, input logic [7:0] data);
        logic [31:0] r;
        r = crcIn ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign accept = in_valid && in_ready;

    // Next CRC and saturating byte count for the byte currently on the input;
    // crc_q/len_q already hold FFFFFFFF/0 while idle, so the same step serves
    // the first byte of a frame.
    always_comb begin
        crc_d = crcByte(crc_q, in_data);
        len_d = len_q;
        if (len_q != {CNT_W{1'b1}}) begin
            len_d = len_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef CRC32_CHECK_STRIP_EN
    logic [2:0] fill_q;
    logic [7:0] dly_q [4];

    // The payload can only advance when the delay line has room or the
    // downstream consumer takes the oldest byte.
    assign in_ready  = (state_q != REPORT) && ((fill_q < 3'd4) || out_ready);
    assign out_valid = in_valid && (fill_q == 3'd4) && (state_q != REPORT);
    assign out_data  = dly_q[0];
    assign out_last  = in_last;

    // Four-byte delay line: the last four bytes of a frame are the FCS, so a
    // byte is only released once four newer bytes have arrived behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= 8'h00;
            end
        end else if (accept) begin
            if (in_last) begin
                fill_q <= 3'd0;
            end else if (fill_q == 3'd4) begin
                dly_q[0] <= dly_q[1];
                dly_q[1] <= dly_q[2];
                dly_q[2] <= dly_q[3];
                dly_q[3] <= in_data;
            end else begin
                dly_q[fill_q[1:0]] <= in_data;
                fill_q             <= fill_q + 3'd1;
            end
        end
    end
`else
    assign in_ready = (state_q != REPORT);
`endif

    // Frame FSM: accumulate CRC and length, latch the verdict on the last byte,
    // then hold the result until it is consumed before accepting the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= 32'hFFFFFFFF;
            len_q     <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_runt  <= 1'b0;
            res_len   <= '0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        crc_q <= crc_d;
                        len_q <= len_d;
                        if (in_last) begin
                            state_q   <= REPORT;
                            res_valid <= 1'b1;
                            res_ok    <= (crc_d == RESIDUE) && (len_d >= CNT_W'(4));
                            res_runt  <= (len_d < CNT_W'(4));
                            res_len   <= len_d;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        crc_q     <= 32'hFFFFFFFF;
                        len_q     <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    crc_q     <= 32'hFFFFFFFF;
                    len_q     <= '0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// tb_crc32_frame_checker
// Directed bench for crc32_frame_checker: frames are driven byte by byte,
// the expected verdict for each frame is queued when it is sent and popped
// when the checker presents its result.
// With CRC32_CHECK_STRIP_EN defined the payload stream is also checked.
module tb_crc32_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic        res_runt;
    logic [15:0] res_len;
`ifdef CRC32_CHECK_STRIP_EN
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [7:0]  outQ [$];
    logic        lastQ [$];
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        ok;
        logic        runt;
        logic [15:0] len;
    } exp_t;

    exp_t       expQ [$];
    logic [7:0] frameQ [$];

    crc32_frame_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef CRC32_CHECK_STRIP_EN
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_runt  (res_runt),
        .res_len   (res_len)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

`ifdef CRC32_CHECK_STRIP_EN
    // Downstream back-pressure changes well after the clock edge so the
    // handshake is stable from the falling edge to the next rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = 1'($urandom_range(0, 1));
    end

    // Record every payload byte that transfers on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) begin
            outQ.push_back(out_data);
            lastQ.push_back(out_last);
        end
    end
`endif

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte and hold it until the checker accepts it.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send the bytes held in frameQ, last flag on the final byte.
    task automatic sendFrame();
        for (int i = 0; i < frameQ.size(); i++) begin
            applyStimulus(frameQ[i], (i == frameQ.size() - 1));
        end
    endtask

    task automatic expectResult(input logic ok, input logic runt, input logic [15:0] len);
        exp_t e;
        e.ok   = ok;
        e.runt = runt;
        e.len  = len;
        expQ.push_back(e);
    endtask

    // Wait for a result, compare it with the oldest expectation, consume it.
    task automatic checkResult(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, ".valid"}, 32'(res_valid), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput({tag, ".scoreboard"}, 32'(expQ.size()), 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, ".ok"},   32'(res_ok),   32'(e.ok));
            checkOutput({tag, ".runt"}, 32'(res_runt), 32'(e.runt));
            checkOutput({tag, ".len"},  32'(res_len),  32'(e.len));
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        res_ready = 1'b0;
`ifdef CRC32_CHECK_STRIP_EN
        out_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        checkOutput("reset.res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset.res_ok",    32'(res_ok),    32'd0);
        checkOutput("reset.res_runt",  32'(res_runt),  32'd0);
        checkOutput("reset.res_len",   32'(res_len),   32'd0);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);

        // "123456789" with its FCS CB F4 39 26 sent LSB-first.
        frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        expectResult(1'b1, 1'b0, 16'd13);
        sendFrame();
        checkResult("check_9");

        // Single zero byte plus FCS.
        frameQ = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        expectResult(1'b1, 1'b0, 16'd5);
        sendFrame();
        checkResult("zero_byte");

        // Same frame with bit 0 of the data corrupted.
        frameQ = '{8'h01, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        expectResult(1'b0, 1'b0, 16'd5);
        sendFrame();
        checkResult("bad_bit");

        // Runt frame.
        frameQ = '{8'hAA, 8'hBB};
        expectResult(1'b0, 1'b1, 16'd2);
        sendFrame();
        checkResult("runt");

        // Single-byte frame: last on the first byte goes straight to report.
        frameQ = '{8'h55};
        expectResult(1'b0, 1'b1, 16'd1);
        sendFrame();
        checkResult("one_byte");

        // Exactly four bytes: long enough, but the residue cannot match.
        frameQ = '{8'h8D, 8'hEF, 8'h02, 8'hD3};
        expectResult(1'b0, 1'b0, 16'd4);
        sendFrame();
        checkResult("four_bytes");

        // Result held while res_ready stays low; input stays blocked.
        frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        expectResult(1'b1, 1'b0, 16'd13);
        sendFrame();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h77;
            checkOutput("hold.res_valid", 32'(res_valid), 32'd1);
            checkOutput("hold.in_ready",  32'(in_ready),  32'd0);
            checkOutput("hold.res_len",   32'(res_len),   32'(expQ[0].len));
            checkOutput("hold.res_ok",    32'(res_ok),    32'(expQ[0].ok));
        end
        in_valid = 1'b0;
        checkResult("hold");
        checkOutput("release.res_valid", 32'(res_valid), 32'd0);
        checkOutput("release.in_ready",  32'(in_ready),  32'd1);

        // Reset in the middle of a frame discards the partial frame.
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h30, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset.res_valid", 32'(res_valid), 32'd0);
        checkOutput("midreset.in_ready",  32'(in_ready),  32'd1);
        frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        expectResult(1'b1, 1'b0, 16'd13);
        sendFrame();
        checkResult("after_reset");
        repeat (5) begin
            @(negedge clk);
            checkOutput("after_reset.no_extra", 32'(res_valid), 32'd0);
        end
        checkOutput("scoreboard.drained", 32'(expQ.size()), 32'd0);

`ifdef CRC32_CHECK_STRIP_EN
        // Payload forwarding with random downstream stalls.
        outQ.delete();
        lastQ.delete();
        frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        expectResult(1'b1, 1'b0, 16'd13);
        sendFrame();
        checkResult("strip");
        checkOutput("strip.count", 32'(outQ.size()), 32'd9);
        for (int i = 0; i < 9 && i < outQ.size(); i++) begin
            checkOutput("strip.data", 32'(outQ[i]),  32'(8'h31 + i));
            checkOutput("strip.last", 32'(lastQ[i]), 32'(i == 8));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
